// File: rtl/fc1_classifier.sv
// fc1_classifier: ReLU on NUM_IN fc0 outputs, then NUM_OUT class scores from
// one serial multiply-accumulate fed by synchronous weight/bias ROMs. Each
// score is streamed as a one-cycle pulse, and the argmax class is reported
// alongside done_fc1.
//
// Input handshake: a beat transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in LOAD. The source may hold
// or drop in_valid at will, and in_valid is ignored whenever in_ready is low.
//
// Score output: score_valid is high for exactly one cycle per class. There is
// no back-pressure. score_idx/score_data stay stable until the next pulse.
module fc1_classifier #(
  parameter int NUM_IN  = 32,
  parameter int NUM_OUT = 10,
  parameter int IN_W    = 38,
  parameter int W_W     = 9,
  parameter int ACC_W   = 54,
  localparam int WA_W   = $clog2(NUM_IN * NUM_OUT),
  localparam int K_W    = $clog2(NUM_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic [WA_W-1:0]         w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic [K_W-1:0]          b_addr,
  input  logic signed [W_W-1:0]   b_data,
  output logic                    score_valid,
  output logic [K_W-1:0]          score_idx,
  output logic signed [ACC_W-1:0] score_data,
  output logic [K_W-1:0]          class_idx,
  output logic                    done_fc1,
  // FSM state for observation: IDLE=0, LOAD=1, MAC=2, EMIT=3, DONE=4
  output logic [2:0]              dbg_state
);

  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PROD_W = IN_W + W_W;

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NUM_IN - 1);
  localparam logic [CNT_W-1:0] MAC_END  = CNT_W'(NUM_IN);
  localparam logic [CNT_W-1:0] MAC_FIRST = CNT_W'(1);
  localparam logic [K_W-1:0]   LAST_K   = K_W'(NUM_OUT - 1);
  localparam logic [WA_W-1:0]  K_STRIDE = WA_W'(NUM_IN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state;
  // cnt counts accepted beats in LOAD and the MAC step j in MAC
  logic [CNT_W-1:0]        cnt;
  logic [K_W-1:0]          k;
  // w_base tracks k*NUM_IN so no multiplier is needed for the ROM address
  logic [WA_W-1:0]         w_base;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] max_score;

  logic signed [IN_W-1:0]  buf_mem [NUM_IN];

  logic [IDX_W-1:0]        rd_idx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_next;

  // At step j the ROM returns the weight addressed at step j-1, so it pairs
  // with buffer entry j-1.
  assign rd_idx   = cnt[IDX_W-1:0] - IDX_W'(1);
  assign prod     = PROD_W'(buf_mem[rd_idx]) * PROD_W'(w_data);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(b_data);
  assign acc_next = (cnt == MAC_FIRST) ? (bias_ext + prod_ext) : (acc + prod_ext);

  assign in_ready    = (state == S_LOAD);
  assign score_valid = (state == S_EMIT);
  assign done_fc1    = (state == S_DONE);
  assign dbg_state   = state;
  assign w_addr      = (state == S_MAC && cnt != MAC_END) ? (w_base + WA_W'(cnt)) : '0;
  assign b_addr      = (state == S_MAC && cnt == '0) ? k : '0;

  // Capture ReLU'd input beats; every run reloads all entries before use.
  always_ff @(posedge clk) begin
    if (enable && state == S_LOAD && in_valid) begin
      buf_mem[cnt[IDX_W-1:0]] <= in_data[IN_W-1] ? '0 : in_data;
    end
  end

  // Control FSM, accumulator, score registers and running argmax.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      w_base     <= '0;
      acc        <= '0;
      max_score  <= '0;
      score_idx  <= '0;
      score_data <= '0;
      class_idx  <= '0;
    end else if (!enable) begin
      state      <= S_IDLE;
      cnt        <= '0;
      k          <= '0;
      w_base     <= '0;
      acc        <= '0;
      max_score  <= '0;
      score_idx  <= '0;
      score_data <= '0;
      class_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_LOAD;
          cnt   <= '0;
          k     <= '0;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST_IN) begin
              state  <= S_MAC;
              cnt    <= '0;
              k      <= '0;
              w_base <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          if (cnt != '0) begin
            acc <= acc_next;
          end
          if (cnt == MAC_END) begin
            state      <= S_EMIT;
            score_idx  <= k;
            score_data <= acc_next;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EMIT: begin
          // Strict compare: on a tie the earlier (lower) class index wins.
          if (k == '0 || acc > max_score) begin
            max_score <= acc;
            class_idx <= k;
          end
          if (k == LAST_K) begin
            state <= S_DONE;
          end else begin
            state  <= S_MAC;
            k      <= k + K_W'(1);
            w_base <= w_base + K_STRIDE;
            cnt    <= '0;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc1_classifier.sv
// Directed bench for fc1_classifier: ROM models, a plain-arithmetic score
// model feeding an expected queue, a per-cycle score checker and a summary.
module tb_fc1_classifier;

  localparam int NUM_IN   = 32;
  localparam int NUM_OUT  = 10;
  localparam int IN_W     = 38;
  localparam int W_W      = 9;
  localparam int ACC_W    = 54;
  localparam int WA_W     = 9;
  localparam int K_W      = 4;
  localparam int CLS_CYC  = NUM_IN + 2;
  localparam int DONE_CYC = NUM_OUT * (NUM_IN + 2) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic signed [IN_W-1:0] in_data = '0;
  logic in_ready;
  logic [WA_W-1:0] w_addr;
  logic signed [W_W-1:0] w_data = '0;
  logic [K_W-1:0] b_addr;
  logic signed [W_W-1:0] b_data = '0;
  logic score_valid;
  logic [K_W-1:0] score_idx;
  logic signed [ACC_W-1:0] score_data;
  logic [K_W-1:0] class_idx;
  logic done_fc1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fc1_classifier dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data), .score_valid(score_valid),
    .score_idx(score_idx), .score_data(score_data), .class_idx(class_idx),
    .done_fc1(done_fc1), .dbg_state(dbg_state)
  );

  // ---------------- ROMs with one-cycle read latency ----------------
  logic signed [W_W-1:0]  wrom [NUM_IN*NUM_OUT];
  logic signed [W_W-1:0]  brom [NUM_OUT];
  logic signed [IN_W-1:0] x [NUM_IN];

  always @(posedge clk) begin
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [ACC_W-1:0] exp_q[$];
  int exp_idx_q[$];
  longint exp_s [NUM_OUT];
  int exp_cls = 0;
  int accept_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_score_valid"}, score_valid, 0);
    check({tag, "_score_idx"}, score_idx, 0);
    check({tag, "_score_data"}, $unsigned(score_data), 0);
    check({tag, "_class_idx"}, class_idx, 0);
    check({tag, "_done"}, done_fc1, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_b_addr"}, b_addr, 0);
    check({tag, "_state_idle"}, dbg_state, 0);
  endtask

  // Score model: score[k] = b[k] + sum_i max(x[i],0) * w[k][i]; argmax with
  // first-occurrence tie rule.
  task automatic model_run();
    longint s;
    longint xi;
    longint best;
    exp_q.delete();
    exp_idx_q.delete();
    for (int k = 0; k < NUM_OUT; k++) begin
      s = longint'(brom[k]);
      for (int i = 0; i < NUM_IN; i++) begin
        xi = (x[i] < 0) ? 64'sd0 : longint'(x[i]);
        s += xi * longint'(wrom[k*NUM_IN + i]);
      end
      exp_s[k] = s;
    end
    exp_cls = 0;
    best = exp_s[0];
    for (int k = 1; k < NUM_OUT; k++) begin
      if (exp_s[k] > best) begin
        best = exp_s[k];
        exp_cls = k;
      end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      exp_q.push_back(ACC_W'(exp_s[k]));
      exp_idx_q.push_back(k);
    end
  endtask

  // Compare process: every score pulse must match the next expected class,
  // value and cycle position.
  int cmp_idx;
  logic [ACC_W-1:0] cmp_val;
  always @(negedge clk) begin
    if (rst_n && score_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_score_valid", score_valid, 0);
      end else begin
        cmp_idx = exp_idx_q.pop_front();
        cmp_val = exp_q.pop_front();
        check("score_idx", score_idx, cmp_idx);
        check("score_data", $unsigned(score_data), cmp_val);
        check("score_cycle", cyc - accept_edge, (cmp_idx + 1) * CLS_CYC - 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_scn(input int id);
    for (int i = 0; i < NUM_IN; i++) begin
      case (id)
        1: x[i] = IN_W'(1);
        2: x[i] = IN_W'(-5);
        3: x[i] = IN_W'(i - 16);
        default: x[i] = IN_W'((64'sd1 <<< 37) - 64'sd1);
      endcase
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        case (id)
          1: wrom[k*NUM_IN + i] = W_W'(k - 4);
          2: wrom[k*NUM_IN + i] = W_W'($urandom_range(0, 511));
          3: wrom[k*NUM_IN + i] = '0;
          default: wrom[k*NUM_IN + i] = W_W'(-256);
        endcase
      end
      case (id)
        1: brom[k] = '0;
        2: brom[k] = W_W'(k);
        3: brom[k] = W_W'(3);
        default: brom[k] = W_W'(-256);
      endcase
    end
  endtask

  // Offer x[0..n-1]; with gaps, every third cycle drops in_valid.
  task automatic send_inputs(input int n, input bit gaps);
    int i;
    int iter;
    i = 0;
    iter = 0;
    while (i < n && iter < 400) begin
      @(negedge clk);
      iter++;
      if (gaps && (iter % 3 == 2)) begin
        in_valid = 1'b0;
        in_data  = '0;
      end else begin
        in_valid = 1'b1;
        in_data  = x[i];
      end
      if (in_valid && in_ready) begin
        i++;
        accept_edge = cyc + 1;
      end
    end
    check("load_beats_accepted", i, n);
  endtask

  task automatic stop_run(input string tag);
    @(negedge clk);
    enable   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle({tag, "_clear"});
  endtask

  task automatic full_run(input int id, input bit gaps, input string tag);
    int w;
    setup_scn(id);
    model_run();
    @(negedge clk);
    enable = 1'b1;
    send_inputs(NUM_IN, gaps);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    w = 0;
    while (!done_fc1 && w < 2 * DONE_CYC) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done"}, done_fc1, 1);
    check({tag, "_done_cycle"}, cyc - accept_edge + 1, DONE_CYC);
    check({tag, "_class_idx"}, class_idx, exp_cls);
    check({tag, "_all_scores_seen"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({tag, "_done_hold"}, done_fc1, 1);
    check({tag, "_class_hold"}, class_idx, exp_cls);
    stop_run(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("enable_low");

    // Ramp weights: scores 32*(k-4), best is class 9.
    full_run(1, 1'b0, "ramp");
    check("pin_ramp_s0", exp_s[0], -128);
    check("pin_ramp_s9", exp_s[9], 160);
    check("pin_ramp_cls", exp_cls, 9);

    // Negative inputs are zeroed, so score is just the bias k.
    full_run(2, 1'b0, "relu");
    check("pin_relu_s5", exp_s[5], 5);
    check("pin_relu_cls", exp_cls, 9);

    // All scores tie at 3: lowest index wins.
    full_run(3, 1'b0, "tie");
    check("pin_tie_s7", exp_s[7], 3);
    check("pin_tie_cls", exp_cls, 0);

    // Largest magnitude: -2^50 + 7936, no wrap.
    full_run(4, 1'b0, "big");
    check("pin_big_s3", exp_s[3], -(64'sd1 <<< 50) + 64'sd7936);
    check("pin_big_cls", exp_cls, 0);

    // Abort after 10 beats, then a clean rerun of the ramp case.
    setup_scn(1);
    @(negedge clk);
    enable = 1'b1;
    send_inputs(10, 1'b0);
    @(negedge clk);
    enable   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("abort");
    full_run(1, 1'b0, "rerun");
    check("pin_rerun_s9", exp_s[9], 160);

    // Asynchronous reset in the middle of class 0 accumulation.
    setup_scn(1);
    @(negedge clk);
    enable = 1'b1;
    send_inputs(NUM_IN, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("pre_reset_w_addr", w_addr, 15);
    check("pre_reset_b_addr", b_addr, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x[0];
    check("reset_hold_ready_a", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("reset_hold_ready_b", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b1;
    check("reset_hold_ready_c", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    full_run(1, 1'b1, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
